// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants used by fetch, decode, hazard and memory blocks.
package mips_pkg;
    localparam int              INST_W           = 32;
    localparam int              ADDR_W           = 32;
    localparam logic [INST_W-1:0] NOP_INST       = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/redirect_hold.sv
// One-entry buffer that parks a redirect target seen while the fetch stage is stalled.
module redirect_hold
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              full,
    output logic [ADDR_W-1:0] pend_pc
);

    // A later load overwrites the entry so the newest redirect wins.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full    <= 1'b0;
            pend_pc <= '0;
        end else if (load) begin
            full    <= 1'b1;
            pend_pc <= redirect_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC register, IF/ID pipeline register, sticky fetch fault and fetch counter.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst_in,
    output logic              if_id_valid,
    output logic [INST_W-1:0] if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              fetch_fault,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-3:0] MEM_LIMIT = (ADDR_W-2)'(MEM_WORDS);

    logic              pend_full;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;
    logic              take;
    logic              misaligned;
    logic              in_range;

    redirect_hold u_hold (
        .clk         (clk),
        .rst         (rst),
        .load        (stall & redirect_valid),
        .clear       (~stall),
        .redirect_pc (redirect_pc),
        .full        (pend_full),
        .pend_pc     (pend_pc)
    );

    assign pc_plus4 = pc + 32'd4;
    assign in_range = (pc[ADDR_W-1:2] < MEM_LIMIT);

    // A live redirect beats a parked one; the parked one beats sequential fetch.
    always_comb begin
        take   = 1'b0;
        target = pc_plus4;
        if (redirect_valid) begin
            take   = 1'b1;
            target = redirect_pc;
        end else if (pend_full) begin
            take   = 1'b1;
            target = pend_pc;
        end
        misaligned = take && (target[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else if (!stall) begin
            pc          <= {target[ADDR_W-1:2], 2'b00};
            if_id_valid <= 1'b1;
            if_id_inst  <= in_range ? inst_in : NOP_INST;
            if_id_pc    <= pc;
            if_id_pc4   <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
            if (!in_range || misaligned) begin
                fetch_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a queue-based fetch model.
module tb_instruction_fetch;
    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc;
    logic [31:0] inst_in;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [MEM_WORDS];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic        m_fault;
    logic [31:0] m_count;
    logic [31:0] pend_q[$];

    always #5 clk = ~clk;

    // Out-of-range reads return junk; the DUT must substitute a nop.
    assign inst_in = (pc[31:2] < MEM_WORDS) ? mem[pc[7:2]] : 32'hDEAD_BEEF;

    instruction_fetch #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .inst_in        (inst_in),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc",          pc,                   m_pc);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("if_id_inst",  if_id_inst,           m_inst);
        chk("if_id_pc",    if_id_pc,             m_ipc);
        chk("if_id_pc4",   if_id_pc4,            m_ipc4);
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        chk("fetch_count", fetch_count,          m_count);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_inst = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        m_fault = 1'b0; m_count = 32'h0;
        pend_q.delete();
    endtask

    // One clock with the given inputs; reference advances from the pre-edge state.
    task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc);
        logic [31:0] t;
        logic        redir;
        stall = st; redirect_valid = rv; redirect_pc = rpc;
        if (st) begin
            if (rv) begin
                pend_q.delete();
                pend_q.push_back(rpc);
            end
        end else begin
            m_valid = 1'b1;
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_count = m_count + 32'd1;
            if ((m_pc >> 2) < MEM_WORDS) m_inst = mem[m_pc[7:2]];
            else begin
                m_inst  = 32'h0;
                m_fault = 1'b1;
            end
            redir = 1'b1;
            if (rv) t = rpc;
            else if (pend_q.size() > 0) t = pend_q[0];
            else redir = 1'b0;
            pend_q.delete();
            if (redir) begin
                if (t % 4 != 0) m_fault = 1'b1;
                m_pc = t - (t % 4);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset wins over whatever else is on the inputs that cycle.
    task automatic do_reset();
        rst = 1'b1;
        stall = 1'($urandom_range(0, 1));
        redirect_valid = 1'($urandom_range(0, 1));
        redirect_pc = $urandom;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        logic [31:0] r;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'h3c01_0000;
        mem[1]  = 32'h3424_0050;
        mem[2]  = 32'h0c00_001b;
        mem[3]  = 32'h2005_0004;
        mem[7]  = 32'h8c89_0000;
        mem[27] = 32'h0000_4020;

        #2;
        do_reset();
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", {31'b0, if_id_valid}, 32'h0);

        // Free-running fetch
        cycle(0, 0, 0);
        chk("tp_inst0", if_id_inst, 32'h3c01_0000);
        cycle(0, 0, 0);
        chk("tp_inst1", if_id_inst, 32'h3424_0050);
        cycle(0, 0, 0);
        chk("tp_inst2", if_id_inst, 32'h0c00_001b);
        chk("tp_pc_c",  pc, 32'h0000_000C);
        chk("tp_count3", fetch_count, 32'd3);

        // jal in ID: delay slot captured, then target
        cycle(0, 1, 32'h6C);
        chk("tp_delay_slot", if_id_inst, 32'h2005_0004);
        chk("tp_pc_6c", pc, 32'h6C);
        cycle(0, 0, 0);
        chk("tp_target_inst", if_id_inst, 32'h0000_4020);

        // Stall at 0x1C
        cycle(0, 1, 32'h1C);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("tp_stall_pc", pc, 32'h1C);
        cycle(0, 0, 0);
        chk("tp_after_stall_inst", if_id_inst, 32'h8c89_0000);
        chk("tp_after_stall_pc", pc, 32'h20);

        // Two redirects during a stall: last wins, buffer drains
        cycle(1, 1, 32'h6C);
        cycle(1, 1, 32'h50);
        cycle(0, 0, 0);
        chk("tp_last_wins", pc, 32'h50);
        cycle(0, 0, 0);
        chk("tp_buffer_empty", pc, 32'h54);

        // Live redirect on the release edge beats the parked one
        cycle(1, 1, 32'h6C);
        cycle(0, 1, 32'h30);
        chk("tp_live_wins", pc, 32'h30);
        cycle(0, 0, 0);
        chk("tp_pending_dropped", pc, 32'h34);

        // Misaligned redirect: aligned PC, sticky fault until reset
        cycle(0, 1, 32'h6E);
        chk("tp_mis_pc", pc, 32'h6C);
        chk("tp_mis_fault", {31'b0, fetch_fault}, 32'h1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        chk("tp_fault_sticky", {31'b0, fetch_fault}, 32'h1);
        do_reset();
        chk("tp_fault_cleared", {31'b0, fetch_fault}, 32'h0);

        // Reset arriving mid-stall with a redirect pending
        cycle(1, 1, 32'h40);
        do_reset();
        cycle(0, 0, 0);
        chk("tp_reset_drops_pending", pc, 32'h4);

        // Out-of-range fetch
        cycle(0, 1, 32'h100);
        cycle(0, 0, 0);
        chk("tp_oor_inst", if_id_inst, 32'h0);
        chk("tp_oor_valid", {31'b0, if_id_valid}, 32'h1);
        chk("tp_oor_fault", {31'b0, fetch_fault}, 32'h1);

        // 32-bit wrap of pc+4
        do_reset();
        cycle(0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        chk("tp_wrap_pc", pc, 32'h0);
        chk("tp_wrap_pc4", if_id_pc4, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                r = 32'($urandom_range(0, 80)) * 32'd4;
                if ($urandom_range(0, 19) == 0) r = r + 32'($urandom_range(1, 3));
                cycle(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 20), r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch (IF) stage of the 5-stage MIPS pipeline. It drives the PC into `instruction_memory` and captures the returned word `instOut` into the IF/ID pipeline register. It supports:
- pipeline stalls from the hazard unit;
- delayed-branch and jump redirects from ID, with the delay slot always executing;
- a one-entry pending-redirect buffer for redirects that arrive during a stall;
- a sticky fetch-fault flag.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `MEM_WORDS`, 64, instruction memory depth in words; fetches at or above this index are out of range
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hazard unit hold; PC and IF/ID are frozen
- `redirect_valid`  in  1  ID stage requests a control transfer this cycle
- `redirect_pc`  in  32  target address (branch, j, jal, jr)
- `pc`  out  32  registered fetch address, to `instruction_memory.pc`
- `inst_in`  in  32  combinational read data, from `instruction_memory.instOut`
- `if_id_valid`  out  1  IF/ID holds a real fetched instruction
- `if_id_inst`  out  32  IF/ID instruction word
- `if_id_pc`  out  32  address of `if_id_inst`
- `if_id_pc4`  out  32  `if_id_pc` + 4 (jal link value is `if_id_pc` + 8, formed in ID)
- `fetch_fault`  out  1  sticky: misaligned redirect or out-of-range fetch seen
- `fetch_count`  out  32  number of instructions captured into IF/ID

## Operation
- Reset values:
  - `pc` = `RESET_PC`
  - `if_id_valid` = 0, `if_id_inst` = 32'h0 (nop), `if_id_pc` = 0, `if_id_pc4` = 0
  - `fetch_fault` = 0, `fetch_count` = 0, pending buffer empty
- `rst` overrides every other input in the same cycle, including a reset that arrives mid-stall or with a redirect pending.
- Advance cycle (`stall` = 0):
  - IF/ID captures `inst_in`, `pc`, `pc`+4; `if_id_valid` = 1; `fetch_count` += 1.
  - Next `pc` priority:
    1. `redirect_valid`, giving `redirect_pc`; the pending buffer is cleared.
    2. Pending buffer full, giving the pending address; the buffer is cleared.
    3. Otherwise `pc`+4.
- Stall cycle (`stall` = 1):
  - `pc`, IF/ID, and `fetch_count` hold.
  - If `redirect_valid`, the buffer loads `redirect_pc`. A later redirect in the same stall overwrites it; last one wins.
- Delay slot: when ID redirects, the instruction currently at `pc` is the delay slot. It is captured normally. There is no flush and no squash.
- Misaligned redirect (`redirect_pc[1:0]` ≠ 0): the PC loads `{redirect_pc[31:2],2'b00}` and `fetch_fault` sets.
- Out of range (`pc[31:2]` ≥ `MEM_WORDS`) on an advance:
  - IF/ID captures 32'h0 (nop) with `if_id_valid` = 1.
  - `fetch_fault` sets.
- `fetch_fault` clears only on `rst`.
- Arithmetic is 32-bit modulo 2^32: `pc`+4 at 32'hFFFF_FFFC wraps to 0. Wrap is not a fault by itself; the out-of-range rule still applies.

## Timing
- `pc` is valid at the start of every cycle. `inst_in` arrives combinationally in the same cycle. Capture happens at the next rising edge, so there is 1 cycle of latency from `pc` to `if_id_inst`.
- A redirect sampled at edge N makes `pc` = target after edge N. The target instruction reaches IF/ID after edge N+1.
- A redirect sampled during a stall takes effect at the first advance edge after the stall releases.
- Throughput is one instruction per non-stalled cycle. There are no bubbles on redirect; the delay slot fills the gap.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_INST` = 32'h0000_0000
  - the default `RESET_PC`
  - the `INST_W` / `ADDR_W` = 32 constants
- The decode, hazard, and memory modules already use these.
- Natural sub-module: `redirect_hold`, the one-entry pending-redirect buffer.
  - Inputs: `clk`, `rst`, load, clear, `redirect_pc`.
  - Outputs: full, pending address.
- The PC register, IF/ID register, fault flag, and counter stay in `instruction_fetch`.

## Test plan
- Reset, then 3 free-running cycles with the standard program loaded:
  - `pc` goes 0 → 4 → 8 → 0xC.
  - `if_id_inst` goes 3c010000, 34240050, 0c00001b; `if_id_pc4` = 4, 8, 0xC.
  - `fetch_count` = 3.
- Redirect while `pc` = 0x0C (jal in ID), `redirect_pc` = 0x6C:
  - The next `if_id_inst` is 20050004, the delay slot.
  - `pc` = 0x6C, and the following capture is 00004020.
- `stall` = 1 for 2 cycles at `pc` = 0x1C, then release:
  - `pc` and `if_id_inst` hold through the stall.
  - `fetch_count` does not increment.
  - The next capture is 8c890000 and `pc` = 0x20.
- Redirect 0x6C asserted during a 2-cycle stall, then 0x50 asserted in the second stall cycle:
  - On release, `pc` = 0x50 (last one wins) and the buffer is empty.
  - A new redirect on the release edge wins over the pending entry.
- `redirect_pc` = 0x6E: `pc` = 0x6C and `fetch_fault` = 1. `fetch_fault` remains 1 until `rst`, and `rst` clears it.
- Redirect to 0x100 with `MEM_WORDS` = 64: the next capture is `if_id_inst` = 0 with `if_id_valid` = 1, and `fetch_fault` = 1.
